// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative HI/LO multiply/divide unit.
// Multiplies use shift-add and divides use restoring division, one bit per
// cycle. Signed operations iterate on magnitudes and fix the signs in FIX.
// Optional feature: define MULDIV_DIV_EN to build the divider and DIV state.
// Without it, DIV/DIVU finish after one busy cycle with div_zero=1.
// Handshake: start is a request strobe that is taken only while the unit is
// in IDLE (busy=0, or the done cycle). Requests at any other time are
// dropped. done pulses for one cycle when an iterative operation completes.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // {partial high, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
    logic               neg_res;  // negate product / quotient in FIX
    logic               dz;       // divide skipped: leave hi/lo alone, flag div_zero
`ifdef MULDIV_DIV_EN
    logic               neg_rem;  // remainder follows the sign of the dividend
    logic               is_div;
`endif

    logic               is_signed, is_mul_op, is_div_op, last_iter;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod_fix;

    assign is_signed = ~op[0];
    assign is_mul_op = (op[2:1] == 2'b00);
    assign is_div_op = (op[2:1] == 2'b01);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign mag1      = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2      = (is_signed && in2[WIDTH-1]) ? -in2 : in2;

    // Shift-add step: add the multiplicand when the current multiplier bit is set.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod_fix = neg_res ? -acc : acc;

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, rem_nx, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] div_next;

    // Restoring step: shift in the next dividend bit, subtract only if it fits.
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opb});
    assign div_diff = div_sh[WIDTH-1:0] - opb;
    assign rem_nx   = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign div_next = {rem_nx, acc[WIDTH-2:0], div_ge};
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && is_mul_op) begin
                    state_nx = MUL;
                end else if (start && is_div_op) begin
`ifdef MULDIV_DIV_EN
                    state_nx = (in2 == '0) ? FIX : DIV;
`else
                    state_nx = FIX;
`endif
                end
            end
            MUL:     if (last_iter) state_nx = FIX;
            DIV:     if (last_iter) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            neg_res  <= 1'b0;
            dz       <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        neg_res <= is_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        if (op == 3'b100) hi <= in1;
                        if (op == 3'b101) lo <= in1;
                        if (is_mul_op) begin
                            acc <= {{WIDTH{1'b0}}, mag2};
                            opb <= mag1;
                            dz  <= 1'b0;
`ifdef MULDIV_DIV_EN
                            is_div <= 1'b0;
`endif
                        end
                        if (is_div_op) begin
`ifdef MULDIV_DIV_EN
                            acc     <= {{WIDTH{1'b0}}, mag1};
                            opb     <= mag2;
                            neg_rem <= is_signed && in1[WIDTH-1];
                            is_div  <= 1'b1;
                            dz      <= (in2 == '0);
`else
                            dz      <= 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
`ifdef MULDIV_DIV_EN
                    acc <= div_next;
                    cnt <= cnt + CW'(1);
`endif
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    cnt      <= '0;
                    if (!dz) begin
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
`else
                        {hi, lo} <= prod_fix;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and randomized checks of alu_muldiv at WIDTH=32
// against an arithmetic reference model of HI/LO.
module tb_alu_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] in1, in2, hi, lo;
    logic         busy, done, div_zero;
    logic [1:0]   state_dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi, m_lo;
    int           checks = 0;
    int           errors = 0;

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
        .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes expected {hi, lo, div_zero, busy cycles} to exp_q.
    task automatic model_push(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [W-1:0] eh, el;
        int          eb;
        logic        edz;
        eh = m_hi; el = m_lo; edz = 1'b0; eb = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; eb = W + 1; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; eb = W + 1; end
            3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
                if (b == 0) begin
                    edz = 1'b1; eb = 1;
                end else begin
                    if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'({32'b0, a}) / longint'({32'b0, b}); r = longint'({32'b0, a}) % longint'({32'b0, b}); end
                    el = q[31:0]; eh = r[31:0]; eb = W + 1;
                end
`else
                edz = 1'b1; eb = 1;
`endif
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
        m_hi = eh; m_lo = el;
        exp_q.push_back(eh);
        exp_q.push_back(el);
        exp_q.push_back(W'(edz));
        exp_q.push_back(W'(eb));
    endtask

    // Driver: called #1 after a rising edge; the request is taken at the next edge.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic [W-1:0] eh, el, edz, eb;
        int n;
        model_push(o, a, b);
        eh = exp_q.pop_front(); el = exp_q.pop_front();
        edz = exp_q.pop_front(); eb = exp_q.pop_front();
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (eb == 0) begin
            check("imm_busy", W'(busy), W'(0));
            check("imm_done", W'(done), W'(0));
            check("imm_hi", hi, eh);
            check("imm_lo", lo, el);
        end else begin
            check("done_drop", W'(done), W'(0));
            n = 0;
            while (busy && n < 100) begin
                n++;
                if (inject && n == 5) begin
                    start = 1'b1; op = 3'b100; in1 = $urandom; in2 = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            check("busy_cycles", W'(n), eb);
            check("done", W'(done), W'(1));
            check("div_zero", W'(div_zero), edz);
            check("hi", hi, eh);
            check("lo", lo, el);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = W'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Directed sequence followed by random operations
    initial begin
        reset = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_state", W'(state_dbg), W'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);   // MULT -1*2
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);   // MULTU, start mid-op ignored
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);   // DIV -7/2
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   // DIV wrap case
        run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0);           // MTHI
        run_op(3'd3, 32'd7, 32'd0, 1'b0);                   // DIVU by zero
        run_op(3'd3, 32'd10, 32'd2, 1'b0);                  // DIVU 10/2
        run_op(3'd5, 32'hCAFE_F00D, 32'h0, 1'b0);           // MTLO
        run_op(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);   // NOP
        run_op(3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0);   // NOP

        // Reset in the middle of a MULT
        run_op(3'd1, 32'd6, 32'd7, 1'b0);
        start = 1'b1; op = 3'd0; in1 = 32'h0001_2345; in2 = 32'h0000_0777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        check("abort_done", W'(done), W'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", W'(done), W'(0));
        end
        run_op(3'd1, 32'd3, 32'd5, 1'b0);

        // Randomized operations, issued back to back on the done cycle
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), bit'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        check("final_done_low", W'(done), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
